// File: rtl/md5_pkg.sv
// md5_pkg: shared constants and padder state type for the MD5 message path.
package md5_pkg;
  localparam int MD5_BLK_W = 512;
  localparam int MD5_WORDS = 16;
  localparam logic [7:0] MD5_PAD_BYTE = 8'h80;
  localparam int MD5_LEN_LO_IDX = 14;
  localparam int MD5_LEN_HI_IDX = 15;
  typedef enum logic [1:0] {FILL, PAD, EMIT, LENBLK} pad_state_t;
endpackage

// File: rtl/md5_pad_word.sv
// md5_pad_word: optional byte reversal, masks bytes >= nbytes and inserts the 0x80 pad byte.
module md5_pad_word
  import md5_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [2:0]  i_nbytes,
  input  logic        i_bswap,
  output logic [31:0] o_word,
  output logic        o_fit
);
  logic [31:0] w_src;
  assign w_src = i_bswap ? {i_word[7:0], i_word[15:8], i_word[23:16], i_word[31:24]} : i_word;
  assign o_fit = i_nbytes < 3'd4;
  always_comb begin
    o_word = '0;
    for (int i = 0; i < 4; i++)
      o_word[8*i +: 8] = 3'(i) < i_nbytes ? w_src[8*i +: 8] : 3'(i) == i_nbytes ? MD5_PAD_BYTE : 8'h00;
  end
endmodule

// File: rtl/md5_msg_padder.sv
// md5_msg_padder: packs 32-bit message words into MD5-padded 512-bit blocks.
// Define MD5_PAD_BSWAP_EN to byte-reverse input words for big-endian sources.
module md5_msg_padder
  import md5_pkg::*;
#(
  parameter int LEN_W = 32
)(
  input  logic                 CLK,
  input  logic                 RSTB,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  input  logic [2:0]           in_nbytes,
  output logic                 blk_valid,
  input  logic                 blk_ready,
  output logic [MD5_BLK_W-1:0] blk_data,
  output logic                 blk_first,
  output logic                 blk_last,
  output logic                 err
);
  pad_state_t r_state, w_next;
  logic [31:0] r_buf [MD5_WORDS];
  logic [3:0] r_wptr;
  logic [LEN_W-1:0] r_bytecnt;
  logic r_first, r_last, r_pend_len, r_pend_80, r_fit, r_err;
  logic [2:0] w_nbytes;
  logic [31:0] w_word;
  logic w_fit, w_bswap, w_len_fits;
  logic [LEN_W:0] w_sum;
  logic [63:0] w_bitlen;

`ifdef MD5_PAD_BSWAP_EN
  assign w_bswap = 1'b1;
`else
  assign w_bswap = 1'b0;
`endif

  assign w_nbytes = !in_last ? 3'd4 : in_nbytes > 3'd4 ? 3'd4 : in_nbytes;
  md5_pad_word u_pad (
    .i_word  (in_data),
    .i_nbytes(w_nbytes),
    .i_bswap (w_bswap),
    .o_word  (w_word),
    .o_fit   (w_fit)
  );

  assign w_sum = {1'b0, r_bytecnt} + (LEN_W+1)'(w_nbytes);
  assign w_bitlen = 64'({r_bytecnt, 3'b000});
  // Length fits when the 0x80 byte landed in word 13 or earlier (p <= 55)
  assign w_len_fits = r_fit ? r_wptr <= 4'd13 : r_wptr <= 4'd12;

  assign in_ready = r_state == FILL;
  assign blk_valid = r_state == EMIT;
  assign blk_first = blk_valid && r_first;
  assign blk_last = blk_valid && r_last;
  assign err = r_err;

  for (genvar k = 0; k < MD5_WORDS; k++) begin : g_out
    assign blk_data[32*k +: 32] = r_buf[k];
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (in_valid) w_next = in_last ? PAD : r_wptr == 4'd15 ? EMIT : FILL;
      PAD:     w_next = EMIT;
      EMIT:    if (blk_ready) w_next = r_pend_len ? LENBLK : FILL;
      default: w_next = EMIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTB)
    if (!RSTB) r_state <= FILL;
    else r_state <= w_next;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < MD5_WORDS; i++) r_buf[i] <= '0;
      r_wptr <= '0;
      r_bytecnt <= '0;
      r_first <= 1'b1;
      r_last <= 1'b0;
      r_pend_len <= 1'b0;
      r_pend_80 <= 1'b0;
      r_fit <= 1'b0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        FILL: if (in_valid) begin
          r_buf[r_wptr] <= w_word;
          r_bytecnt <= w_sum[LEN_W] ? '1 : w_sum[LEN_W-1:0];
          r_err <= r_err | w_sum[LEN_W];
          r_fit <= w_fit;
          if (!in_last && r_wptr != 4'd15) r_wptr <= r_wptr + 4'd1;
        end
        PAD: begin
          if (!r_fit && r_wptr != 4'd15) r_buf[r_wptr + 4'd1] <= {24'h0, MD5_PAD_BYTE};
          if (w_len_fits) begin
            r_buf[MD5_LEN_LO_IDX] <= w_bitlen[31:0];
            r_buf[MD5_LEN_HI_IDX] <= w_bitlen[63:32];
          end
          r_last <= w_len_fits;
          r_pend_len <= !w_len_fits;
          r_pend_80 <= !r_fit && r_wptr == 4'd15;
        end
        EMIT: if (blk_ready) begin
          r_first <= r_last;
          r_last <= 1'b0;
          if (!r_pend_len) begin
            for (int i = 0; i < MD5_WORDS; i++) r_buf[i] <= '0;
            r_wptr <= '0;
            if (r_last) r_bytecnt <= '0;
          end
        end
        default: begin
          for (int i = 0; i < MD5_WORDS; i++) r_buf[i] <= '0;
          r_buf[0] <= r_pend_80 ? {24'h0, MD5_PAD_BYTE} : 32'h0;
          r_buf[MD5_LEN_LO_IDX] <= w_bitlen[31:0];
          r_buf[MD5_LEN_HI_IDX] <= w_bitlen[63:32];
          r_wptr <= '0;
          r_last <= 1'b1;
          r_pend_len <= 1'b0;
          r_pend_80 <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md5_msg_padder.sv
// tb_md5_msg_padder: directed checks of MD5 padding, block sequencing, backpressure and overflow.
module tb_md5_msg_padder;
  logic CLK = 1'b0, RSTB = 1'b0, in_valid = 1'b0, in_last = 1'b0, blk_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0] in_nbytes = '0;
  logic in_ready, blk_valid, blk_first, blk_last, err;
  logic in_ready8, blk_valid8, blk_first8, blk_last8, err8;
  logic [511:0] blk_data, blk_data8, got, got8, exp;
  logic gf, gl;
  int n_pass = 0, n_total = 0;

  md5_msg_padder dut (
    .CLK(CLK), .RSTB(RSTB), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes), .blk_valid(blk_valid), .blk_ready(blk_ready),
    .blk_data(blk_data), .blk_first(blk_first), .blk_last(blk_last), .err(err)
  );

  md5_msg_padder #(.LEN_W(8)) dut8 (
    .CLK(CLK), .RSTB(RSTB), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
    .in_last(in_last), .in_nbytes(in_nbytes), .blk_valid(blk_valid8), .blk_ready(blk_ready),
    .blk_data(blk_data8), .blk_first(blk_first8), .blk_last(blk_last8), .err(err8)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] nb);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_nbytes = nb;
    while (!in_ready && n < 100) begin @(posedge CLK); #1; n++; end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_word timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] d, output logic [511:0] d8, output logic f, output logic l);
    int n = 0;
    while (!blk_valid && n < 100) begin @(posedge CLK); #1; n++; end
    if (!blk_valid) begin
      n_total++;
      $display("FAIL get_block timeout: blk_valid=%b required 1", blk_valid);
    end
    d = blk_data; d8 = blk_data8; f = blk_first; l = blk_last;
    blk_ready = 1'b1;
    @(posedge CLK); #1;
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    RSTB = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_total++;
    if ({in_ready, blk_valid, blk_first, blk_last, err, err8} !== 6'b100000)
      $display("FAIL reset_flags: got %b required 100000", {in_ready, blk_valid, blk_first, blk_last, err, err8});
    else n_pass++;
    n_total++;
    if (blk_data !== '0) $display("FAIL reset_data: got %h required 0", blk_data); else n_pass++;
    RSTB = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_abc();
    send_word(32'h00636261, 1'b1, 3'd3);
    n_total++;
    if ({blk_valid, in_ready} !== 2'b00) $display("FAIL abc_pad_cycle: valid,ready=%b required 00", {blk_valid, in_ready});
    else n_pass++;
    @(posedge CLK); #1;
    n_total++;
    if (blk_valid !== 1'b1) $display("FAIL abc_latency: blk_valid=%b required 1", blk_valid); else n_pass++;
    get_block(got, got8, gf, gl);
    exp = '0; exp[31:0] = 32'h80636261; exp[14*32 +: 32] = 32'h18;
    n_total++;
    if (got !== exp) $display("FAIL abc_data: got %h required %h", got, exp); else n_pass++;
    n_total++;
    if ({gf, gl} !== 2'b11) $display("FAIL abc_first_last: got %b required 11", {gf, gl}); else n_pass++;
  endtask

  task automatic test_empty();
    send_word(32'hdeadbeef, 1'b1, 3'd0);
    get_block(got, got8, gf, gl);
    exp = '0; exp[31:0] = 32'h80;
    n_total++;
    if (got !== exp) $display("FAIL empty_data: got %h required %h", got, exp); else n_pass++;
    n_total++;
    if ({gf, gl} !== 2'b11) $display("FAIL empty_first_last: got %b required 11", {gf, gl}); else n_pass++;
  endtask

  task automatic test_56();
    exp = '0;
    for (int i = 0; i < 14; i++) begin
      send_word(32'h11110000 + i, i == 13, 3'd4);
      exp[32*i +: 32] = 32'h11110000 + i;
    end
    exp[14*32 +: 32] = 32'h80;
    get_block(got, got8, gf, gl);
    n_total++;
    if (got !== exp) $display("FAIL b56_blk1: got %h required %h", got, exp); else n_pass++;
    n_total++;
    if ({gf, gl} !== 2'b10) $display("FAIL b56_blk1_flags: got %b required 10", {gf, gl}); else n_pass++;
    n_total++;
    if (blk_valid !== 1'b0) $display("FAIL b56_lenblk_gap: blk_valid=%b required 0", blk_valid); else n_pass++;
    @(posedge CLK); #1;
    n_total++;
    if (blk_valid !== 1'b1) $display("FAIL b56_lenblk_rise: blk_valid=%b required 1", blk_valid); else n_pass++;
    get_block(got, got8, gf, gl);
    exp = '0; exp[14*32 +: 32] = 32'h1C0;
    n_total++;
    if (got !== exp) $display("FAIL b56_blk2: got %h required %h", got, exp); else n_pass++;
    n_total++;
    if ({gf, gl} !== 2'b01) $display("FAIL b56_blk2_flags: got %b required 01", {gf, gl}); else n_pass++;
  endtask

  task automatic test_64();
    exp = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'hA5A50000 + i, i == 15, 3'd4);
      exp[32*i +: 32] = 32'hA5A50000 + i;
    end
    get_block(got, got8, gf, gl);
    n_total++;
    if (got !== exp || {gf, gl} !== 2'b10) $display("FAIL b64_blk1: got %h/%b required %h/10", got, {gf, gl}, exp);
    else n_pass++;
    get_block(got, got8, gf, gl);
    exp = '0; exp[31:0] = 32'h80; exp[14*32 +: 32] = 32'h200;
    n_total++;
    if (got !== exp) $display("FAIL b64_blk2: got %h required %h", got, exp); else n_pass++;
    n_total++;
    if ({gf, gl} !== 2'b01) $display("FAIL b64_blk2_flags: got %b required 01", {gf, gl}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp = '0;
    for (int i = 0; i < 16; i++) begin
      send_word(32'h22220000 + i, 1'b0, 3'd4);
      exp[32*i +: 32] = 32'h22220000 + i;
    end
    n_total++;
    if (blk_valid !== 1'b1) $display("FAIL b2b_full_latency: blk_valid=%b required 1", blk_valid); else n_pass++;
    get_block(got, got8, gf, gl);
    n_total++;
    if (got !== exp || {gf, gl} !== 2'b10) $display("FAIL b2b_blk1: got %h/%b required %h/10", got, {gf, gl}, exp);
    else n_pass++;
    send_word(32'h33330000, 1'b0, 3'd4);
    send_word(32'h44332211, 1'b1, 3'd2);
    get_block(got, got8, gf, gl);
    exp = '0; exp[31:0] = 32'h33330000; exp[63:32] = 32'h00802211; exp[14*32 +: 32] = 32'h230;
    n_total++;
    if (got !== exp) $display("FAIL b2b_blk2: got %h required %h", got, exp); else n_pass++;
    n_total++;
    if ({gf, gl} !== 2'b01) $display("FAIL b2b_blk2_flags: got %b required 01", {gf, gl}); else n_pass++;
  endtask

  task automatic test_backpressure();
    send_word(32'h00636261, 1'b1, 3'd3);
    @(posedge CLK); #1;
    exp = '0; exp[31:0] = 32'h80636261; exp[14*32 +: 32] = 32'h18;
    in_valid = 1'b1; in_data = 32'hFFFFFFFF; in_last = 1'b1; in_nbytes = 3'd0;
    for (int c = 0; c < 5; c++) begin
      n_total++;
      if (blk_data !== exp || blk_valid !== 1'b1 || in_ready !== 1'b0)
        $display("FAIL bp_hold%0d: data=%h valid=%b ready=%b required %h 1 0", c, blk_data, blk_valid, in_ready, exp);
      else n_pass++;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    blk_ready = 1'b1;
    @(posedge CLK); #1;
    blk_ready = 1'b0;
    n_total++;
    if (blk_valid !== 1'b0) $display("FAIL bp_release: blk_valid=%b required 0", blk_valid); else n_pass++;
    @(posedge CLK); #1;
    n_total++;
    if ({blk_valid, in_ready} !== 2'b01) $display("FAIL bp_single: valid,ready=%b required 01", {blk_valid, in_ready});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 7; i++) send_word(32'h77770000 + i, 1'b0, 3'd4);
    #2 RSTB = 1'b0;
    #1;
    n_total++;
    if ({in_ready, blk_valid} !== 2'b10 || blk_data !== '0)
      $display("FAIL midreset_clear: ready,valid=%b data=%h required 10 and 0", {in_ready, blk_valid}, blk_data);
    else n_pass++;
    @(posedge CLK); #1;
    RSTB = 1'b1;
    test_abc();
  endtask

  task automatic test_overflow();
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 16; i++) begin
        if (b == 3 && i == 15) begin
          n_total++;
          if (err8 !== 1'b0) $display("FAIL ovf_before: err8=%b required 0", err8); else n_pass++;
        end
        send_word(32'h55550000 + i, b == 3 && i == 15, 3'd4);
      end
      if (b == 3) begin
        n_total++;
        if ({err8, err} !== 2'b10) $display("FAIL ovf_set: err8,err=%b required 10", {err8, err}); else n_pass++;
      end
      get_block(got, got8, gf, gl);
    end
    get_block(got, got8, gf, gl);
    n_total++;
    if (got8[14*32 +: 32] !== 32'h7F8) $display("FAIL ovf_len8: got %h required 000007f8", got8[14*32 +: 32]);
    else n_pass++;
    exp = '0; exp[31:0] = 32'h80; exp[14*32 +: 32] = 32'h800;
    n_total++;
    if (got !== exp) $display("FAIL ovf_len32: got %h required %h", got, exp); else n_pass++;
    repeat (3) @(posedge CLK);
    #1;
    n_total++;
    if (err8 !== 1'b1) $display("FAIL ovf_sticky: err8=%b required 1", err8); else n_pass++;
    RSTB = 1'b0;
    #1;
    n_total++;
    if (err8 !== 1'b0) $display("FAIL ovf_reset: err8=%b required 0", err8); else n_pass++;
    @(posedge CLK); #1;
    RSTB = 1'b1;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_56();
    test_64();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_overflow();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/md5_msg_padder.md
# md5_msg_padder

Upstream message-formatting stage for the MD5 integrity-check path. It accepts the raw content stream as 32-bit little-endian words and applies MD5 padding: a 0x80 byte, zero fill, and a 64-bit bit-length. It emits complete 512-bit blocks over a valid/ready handshake to the core-driving controller. Word 0 of each block sits in bits [31:0], matching the controller's msg_x0..msg_x15 slicing.

## Interface
- LEN_W, default 32: width of the message byte counter. Maximum message length is 2^LEN_W−1 bytes.
- CLK  in  1  clock; all state updates on the rising edge.
- RSTB  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  padder can accept a word.
- in_data  in  32  message word; byte 0 in [7:0].
- in_last  in  1  final word of the message.
- in_nbytes  in  3  valid bytes in the last word, 0..4 (low bytes first). Ignored when in_last=0, where 4 is implied.
- blk_valid  out  1  block available.
- blk_ready  in  1  consumer accepts the block.
- blk_data  out  512  padded block; word k at [32k+31:32k].
- blk_first  out  1  block is the first of its message (qualified by blk_valid).
- blk_last  out  1  block is the last of its message (qualified by blk_valid).
- err  out  1  sticky length-overflow flag.

## Operation
- States: FILL, PAD, EMIT, LENBLK. Reset enters FILL with buffer=0, wptr=0, bytecnt=0, first=1.
- FILL: in_ready=1.
  - Each accepted word is written at word wptr. bytecnt increases by 4, or by in_nbytes when in_last=1.
  - Non-last word at wptr=15 → EMIT (last=0). Otherwise wptr increments.
  - Last word → PAD.
- PAD (1 cycle): in the last word, bytes at positions ≥ in_nbytes are zeroed, and 0x80 goes at byte in_nbytes if in_nbytes<4. Words after it are zeroed. p = byte position of 0x80 within the block.
  - If p≤55: word14 = bitlen[31:0], word15 = bitlen[63:32], bitlen = {bytecnt,3'b000} zero-extended to 64 bits. → EMIT, last=1.
  - Else → EMIT, last=0, pend_len=1. pend_80 is set when in_nbytes=4 at wptr=15, i.e. the 0x80 did not fit in this block.
- EMIT: blk_valid=1, and blk_data/blk_first/blk_last hold stable. On blk_ready:
  - pend_len → LENBLK.
  - last → FILL, clearing bytecnt, buffer and wptr, and setting first=1.
  - Otherwise → FILL with buffer and wptr cleared and first=0.
- LENBLK (1 cycle): block is all zeros, with word0=0x00000080 if pend_80, word14/15=bitlen. → EMIT, last=1, pend flags cleared.
- Zero-length message: in_last with in_nbytes=0 at wptr=0 yields one block with word0=0x00000080 and bitlen=0.
- Overflow: if bytecnt would exceed 2^LEN_W−1, err is set (sticky until reset) and bytecnt saturates. Blocks are still emitted.

## Timing
- Reset values: in_ready=1 (FILL), blk_valid=0, blk_data=0, blk_first=0, blk_last=0, err=0.
- Full non-last block: word 15 accepted at cycle t → blk_valid at t+1.
- Last word accepted at t → PAD at t+1 → blk_valid at t+2.
- Second (length-only) block: blk_valid rises 2 cycles after the first block handshake (through LENBLK).
- in_ready=0 in PAD, EMIT and LENBLK. No input is accepted while a block is pending.
- blk_valid, once high, stays high until blk_ready=1. blk_data must not change while blk_valid=1 and blk_ready=0.
- Asynchronous RSTB assertion mid-message discards the partial block, pending flags and bytecnt. The next message starts clean with first=1.

## Configuration
- MD5_PAD_BSWAP_EN defined: in_data is byte-reversed on capture, so byte 0 is taken from [31:24] and in_nbytes counts from the MSB end. This serves big-endian content memories.
- Not defined: data is captured as-is, with byte 0 in [7:0].
- Padding and length placement are identical in both cases.

## Structure
- Shared package md5_pkg:
  - MD5_BLK_W=512, MD5_WORDS=16, MD5_PAD_BYTE=8'h80, MD5_LEN_LO_IDX=14, MD5_LEN_HI_IDX=15.
  - Padder state enum type.
- One sub-module, md5_pad_word: combinational. Takes a word, nbytes and bswap, and produces the masked word with 0x80 inserted plus a flag saying whether the pad byte fit.

## Test plan
- "abc": in_data=0x00636261, in_nbytes=3, last → one block: word0=0x80636261, words1–13=0, word14=0x18, word15=0, first=last=1.
- Empty message: in_nbytes=0, last → word0=0x00000080, word14=0, word15=0, first=last=1.
- 56-byte message (14 words, last nbytes=4):
  - Block 1: word14=0x00000080, word15=0, last=0.
  - Block 2: all zero except word14=0x1C0, last=1, first=0.
- 64-byte message: block 1 = data, last=0 → block 2: word0=0x80, word14=0x200, last=1.
- Backpressure: hold blk_ready=0 for 5 cycles during EMIT → blk_data unchanged, in_ready=0. Release → single handshake.
- Reset after 7 words, then send "abc" → identical to the "abc" case.
- With LEN_W=8, send 256 bytes → err=1 from then on, stays high until RSTB.
